// File: rtl/cpu_check_monitor.sv
// ============================================================================
// Module   : cpu_check_monitor
// Brief    : Record counters, error latch and sticky streak alarm downstream of
//            the trace-line checker. Optional macro CPU_MON_ERRCLS_EN adds the
//            per-error-class counters e0..e3 (read-back selects 4..7).
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_check_monitor #(
  parameter int CNT_W    = 16,
  parameter int ALARM_TH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       format_type,
  input  logic [3:0]       error_code,
  input  logic             clr,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rec_valid,
  output logic [3:0]       last_err,
  output logic             alarm
);

  localparam logic [7:0] C_TH = 8'(ALARM_TH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       prev_ft_q;
  logic [CNT_W-1:0] tot_q, tot_d, regc_q, regc_d, memc_q, memc_d, errc_q, errc_d;
  logic [7:0]       streak_q, streak_d;
  logic [3:0]       last_err_q, last_err_d;
  logic             alarm_q, alarm_d;
  logic             rec_valid_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             w_accept;
  logic             w_err;

  // Rising-level detect: 11 also updates prev_ft, so 11->01 is never a record.
  assign w_accept = ((format_type == 2'b01) || (format_type == 2'b10)) &&
                    (prev_ft_q == 2'b00);
  assign w_err    = (error_code != 4'd0);

  always_comb begin
    tot_d      = tot_q;
    regc_d     = regc_q;
    memc_d     = memc_q;
    errc_d     = errc_q;
    streak_d   = streak_q;
    last_err_d = last_err_q;
    alarm_d    = alarm_q;
    if (clr) begin
      tot_d      = '0;
      regc_d     = '0;
      memc_d     = '0;
      errc_d     = '0;
      streak_d   = '0;
      last_err_d = '0;
      alarm_d    = 1'b0;
    end else if (w_accept) begin
      tot_d = sat_inc(tot_q);
      if (format_type == 2'b01) regc_d = sat_inc(regc_q);
      if (format_type == 2'b10) memc_d = sat_inc(memc_q);
      if (w_err) begin
        errc_d     = sat_inc(errc_q);
        last_err_d = error_code;
        streak_d   = (streak_q >= C_TH) ? C_TH : streak_q + 8'd1;
      end else begin
        streak_d   = '0;
      end
      alarm_d = alarm_q | (streak_d == C_TH);
    end
  end

`ifdef CPU_MON_ERRCLS_EN
  logic [CNT_W-1:0] ecls_q [4];
  logic [CNT_W-1:0] ecls_d [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ecls_d[k] = ecls_q[k];
      if (clr)
        ecls_d[k] = '0;
      else if (w_accept && error_code[k])
        ecls_d[k] = sat_inc(ecls_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) ecls_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) ecls_q[k] <= ecls_d[k];
    end
  end
`endif

  always_comb begin
    rd_data_d = '0;
    case (sel)
      3'd0:    rd_data_d = tot_q;
      3'd1:    rd_data_d = regc_q;
      3'd2:    rd_data_d = memc_q;
      3'd3:    rd_data_d = errc_q;
`ifdef CPU_MON_ERRCLS_EN
      3'd4:    rd_data_d = ecls_q[0];
      3'd5:    rd_data_d = ecls_q[1];
      3'd6:    rd_data_d = ecls_q[2];
      3'd7:    rd_data_d = ecls_q[3];
`endif
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ft_q   <= 2'b00;
      tot_q       <= '0;
      regc_q      <= '0;
      memc_q      <= '0;
      errc_q      <= '0;
      streak_q    <= '0;
      last_err_q  <= '0;
      alarm_q     <= 1'b0;
      rec_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      prev_ft_q   <= format_type;
      tot_q       <= tot_d;
      regc_q      <= regc_d;
      memc_q      <= memc_d;
      errc_q      <= errc_d;
      streak_q    <= streak_d;
      last_err_q  <= last_err_d;
      alarm_q     <= alarm_d;
      rec_valid_q <= w_accept & ~clr;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rec_valid = rec_valid_q;
  assign last_err  = last_err_q;
  assign alarm     = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_check_monitor.sv
// ============================================================================
// Module   : tb_cpu_check_monitor
// Brief    : Directed self-checking bench for cpu_check_monitor (CNT_W=4, ALARM_TH=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_check_monitor;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       format_type = 2'b00;
  logic [3:0]       error_code = 4'd0;
  logic             clr = 1'b0;
  logic [2:0]       sel = 3'd0;
  logic [CNT_W-1:0] rd_data;
  logic             rec_valid;
  logic [3:0]       last_err;
  logic             alarm;

  int n_chk  = 0;
  int n_pass = 0;

  cpu_check_monitor #(.CNT_W(CNT_W), .ALARM_TH(3)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .format_type(format_type),
    .error_code (error_code),
    .clr        (clr),
    .sel        (sel),
    .rd_data    (rd_data),
    .rec_valid  (rec_valid),
    .last_err   (last_err),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [1:0] ft, input logic [3:0] ec);
    format_type = ft;
    error_code  = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input logic [1:0] ft, input logic [3:0] ec);
    step(ft, ec);
    step(2'b00, 4'd0);
  endtask

  task automatic rd(input logic [2:0] s, input string tag, input logic [31:0] exp);
    sel = s;
    @(posedge clk);
    #1;
    chk(tag, 32'(rd_data), exp);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(2'b00, 4'd0);
    clr = 1'b0;
  endtask

  int pulses;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rec_valid", 32'(rec_valid), 0);
    chk("rst_last_err", 32'(last_err), 0);
    chk("rst_alarm", 32'(alarm), 0);
    reset = 1'b1;
    step(2'b00, 4'd0);

    // Basic register then memory record
    step(2'b01, 4'd0);
    chk("t1_rv1", 32'(rec_valid), 1);
    step(2'b00, 4'd0);
    chk("t1_rv_gap", 32'(rec_valid), 0);
    step(2'b10, 4'd0);
    chk("t1_rv2", 32'(rec_valid), 1);
    step(2'b00, 4'd0);
    rd(3'd0, "t1_tot", 2);
    rd(3'd1, "t1_regc", 1);
    rd(3'd2, "t1_memc", 1);
    rd(3'd3, "t1_errc", 0);
    chk("t1_alarm", 32'(alarm), 0);

    // Held level counts once; 11 then 01 is not a record
    do_clr();
    rd(3'd0, "t2_tot_clr", 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 4'd0);
      pulses += int'(rec_valid);
    end
    step(2'b11, 4'd0);
    pulses += int'(rec_valid);
    step(2'b01, 4'd0);
    pulses += int'(rec_valid);
    step(2'b00, 4'd0);
    pulses += int'(rec_valid);
    chk("t2_pulses", 32'(pulses), 1);
    rd(3'd0, "t2_tot", 1);

    // Error streak reaches the threshold on the third record
    do_clr();
    rec(2'b01, 4'b0001);
    rec(2'b10, 4'b0010);
    chk("t3_alarm_early", 32'(alarm), 0);
    step(2'b01, 4'b1010);
    chk("t3_alarm_set", 32'(alarm), 1);
    chk("t3_last_err", 32'(last_err), 32'b1010);
    step(2'b00, 4'd0);
    rd(3'd3, "t3_errc", 3);
`ifdef CPU_MON_ERRCLS_EN
    rd(3'd4, "t3_e0", 1);
    rd(3'd5, "t3_e1", 2);
    rd(3'd6, "t3_e2", 0);
    rd(3'd7, "t3_e3", 1);
`else
    rd(3'd5, "t3_sel5", 0);
`endif
    rec(2'b10, 4'd0);
    chk("t3_alarm_sticky", 32'(alarm), 1);
    chk("t3_last_err_kept", 32'(last_err), 32'b1010);

    // Clean record breaks the streak
    do_clr();
    chk("t4_alarm_clr", 32'(alarm), 0);
    chk("t4_last_err_clr", 32'(last_err), 0);
    rec(2'b01, 4'b0100);
    rec(2'b01, 4'b0000);
    rec(2'b10, 4'b0100);
    rec(2'b01, 4'b0100);
    chk("t4_alarm_streak2", 32'(alarm), 0);
    rec(2'b10, 4'b0100);
    chk("t4_alarm_streak3", 32'(alarm), 1);

    // Clear in the same cycle as an accepted record drops it
    clr = 1'b1;
    step(2'b01, 4'b0001);
    clr = 1'b0;
    chk("t5_rv", 32'(rec_valid), 0);
    chk("t5_alarm", 32'(alarm), 0);
    chk("t5_last_err", 32'(last_err), 0);
    step(2'b00, 4'd0);
    rd(3'd0, "t5_tot", 0);
    rd(3'd3, "t5_errc", 0);
    rec(2'b01, 4'd0);
    rd(3'd0, "t5_tot_next", 1);

    // Saturation at 2^CNT_W-1
    do_clr();
    for (int i = 0; i < 17; i++) rec(2'b01, 4'd0);
    rd(3'd0, "t6_tot_sat", 15);
    rd(3'd1, "t6_regc_sat", 15);
    rd(3'd5, "t6_sel5", 0);

    // Reset with a record pending, then level held across release counts once
    format_type = 2'b01;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_rst_rv", 32'(rec_valid), 0);
    chk("t7_rst_rd", 32'(rd_data), 0);
    reset = 1'b1;
    step(2'b01, 4'd0);
    chk("t7_rv_after_rst", 32'(rec_valid), 1);
    step(2'b00, 4'd0);
    rd(3'd0, "t7_tot", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_check_monitor.md
# cpu_check_monitor

Statistics and alarm stage directly downstream of the CPU trace-line checker. It consumes the checker's per-line `format_type`/`error_code` outputs and counts accepted records by kind and by error class. It latches the most recent error code and raises a sticky alarm after a run of consecutive erroneous records. Counters are read back through a registered select port for the test harness or a display front end.

## Interface
- `CNT_W`, default 16: width of every counter and of `rd_data`.
- `ALARM_TH`, default 3: number of consecutive erroneous records that sets `alarm`. Legal range 1..255.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `format_type` in 2: checker output. 00 = none, 01 = register record, 10 = memory record, 11 = ignored.
- `error_code` in 4: checker output, sampled with `format_type`. bit0 = time, bit1 = pc, bit2 = addr, bit3 = grf.
- `clr` in 1: synchronous clear pulse for all counters, `last_err` and `alarm`.
- `sel` in 3: read-back select.
- `rd_data` out CNT_W: registered value of the selected counter.
- `rec_valid` out 1: one-cycle pulse per counted record.
- `last_err` out 4: `error_code` of the most recent erroneous record.
- `alarm` out 1: sticky consecutive-error alarm.

## Operation
- **Record detection**
  - Keep a registered copy `prev_ft` of `format_type`.
  - A record is accepted in a cycle when `format_type` is 01 or 10 and `prev_ft` is 00.
  - A level held for several cycles counts once.
  - 11 is never a record. It still updates `prev_ft`, so 11→01 is not accepted.
- **Counters** (all saturate at 2^CNT_W−1 and never wrap)
  - `tot`: incremented on every accepted record.
  - `regc`: incremented when the record type is 01.
  - `memc`: incremented when the record type is 10.
  - `errc`: incremented when `error_code` != 0.
- **Error-class counters** (`CPU_MON_ERRCLS_EN` only)
  - `e0`..`e3`: `ek` increments when `error_code[k]` = 1.
  - Several classes may increment in the same cycle.
- **Error latch and streak**
  - On an erroneous record, `last_err` ← `error_code`. Clean records leave it unchanged.
  - `streak` is an 8-bit count of consecutive erroneous records. It increments (saturating at ALARM_TH) on an erroneous record and resets to 0 on a clean one.
  - `alarm` is set when `streak` reaches ALARM_TH.
  - `alarm` stays set regardless of later clean records until `clr` or `reset`.
- **Read-back**
  - `rd_data` ← mux(`sel`): 0 `tot`, 1 `regc`, 2 `memc`, 3 `errc`, 4..7 `e0`..`e3`.
  - Without the macro, selects 4..7 return 0.
- **Clear**
  - `clr` = 1 zeroes every counter, `streak`, `last_err` and `alarm`. `prev_ft` is not cleared.
  - `clr` has priority: a record accepted in the same cycle is dropped entirely (no count, no `rec_valid`).
- **Reset**
  - Reset while a record is pending discards it.
  - After release, `prev_ft` = 00, so a `format_type` already held at 01 counts on the first active edge.

## Timing
- Reset values: `rd_data` = 0, `rec_valid` = 0, `last_err` = 0, `alarm` = 0, all counters and `streak` = 0, `prev_ft` = 00.
- Edge t is the rising edge that samples a qualifying `format_type`/`error_code`.
  - Counters, `last_err` and `streak` are updated by edge t.
  - `rec_valid` is high for exactly the cycle following edge t.
  - `alarm` is set by the same edge t whose record brings `streak` to ALARM_TH, so it is visible in the cycle after edge t.
  - `rd_data` reflects counter values after edge t from edge t+1 onward: a one-cycle read latency, with `sel` sampled at edge t+1.
- No back-pressure. The block accepts a record on any cycle. Two records need at least one 00 cycle between them, which the checker always provides.

## Configuration
- `CPU_MON_ERRCLS_EN` defined: the four per-class counters `e0`..`e3` are built, and selects 4..7 return them.
- Not defined: the per-class counters are not synthesised, selects 4..7 return 0, and all other behaviour is identical.

## Test plan
- Reset, then 01/0000 for 1 cycle, 00 for 1, 10/0000 for 1 → `tot` = 2, `regc` = 1, `memc` = 1, `errc` = 0; `rec_valid` pulses twice; `alarm` = 0.
- `format_type` held at 01 for 5 cycles → `tot` = 1. A following 11 then 01 (no intervening 00) → `tot` still 1.
- ALARM_TH = 3: three records with `error_code` 0001, 0010, 1010 → `alarm` = 1 in the cycle after the third record; `last_err` = 1010; with the macro, `e1` = 2, `e3` = 1, `e0` = 1. A further clean record leaves `alarm` = 1.
- Errors 0100, clean, 0100, 0100 with ALARM_TH = 3 → `alarm` stays 0 and `streak` = 2.
- `clr` asserted in the same cycle as an accepted record → all counters 0, no `rec_valid`, `alarm` = 0; the next record gives `tot` = 1.
- CNT_W = 4: 17 clean records → `tot` = 15 (saturated). Without the macro, `sel` = 5 → `rd_data` = 0.
